// File: rtl/vectoring_pkg.sv
// Shared widths for the vectoring scheduler.
// Tag width and full-angle width helpers.
package vectoring_pkg;

    localparam int QUAD_W = 2;

    function automatic int tag_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int full_angle_w(input int aw);
        return aw + QUAD_W;
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO recording which requester owns each
// sample currently inside the vectoring core.
module tag_fifo #(
    parameter int DEPTH = 32,
    parameter int TW    = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      push,
    input  logic [TW-1:0]             push_tag,
    input  logic                      pop,
    output logic [TW-1:0]             pop_tag,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_tag = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/vectoring_scheduler.sv
// Round-robin scheduler sharing one in-order vectoring core
// among NREQ requesters; results are routed back by tag.
module vectoring_scheduler
    import vectoring_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int ISSUE_GAP = 1,
    parameter int DEPTH     = 32
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ-1:0][DW-1:0]       req_x_i,
    input  logic [NREQ-1:0][DW-1:0]       req_y_i,
    output logic                          core_valid_o,
    output logic [DW-1:0]                 core_x_o,
    output logic [DW-1:0]                 core_y_o,
    input  logic                          core_valid_i,
    input  logic [DW-1:0]                 core_r_i,
    input  logic [AW-1:0]                 core_angle_i,
    input  logic [1:0]                    core_quadrant_i,
    output logic [NREQ-1:0]               rsp_valid_o,
    output logic [DW-1:0]                 rsp_r_o,
    output logic [full_angle_w(AW)-1:0]   rsp_angle_o,
    output logic                          err_o
);

    localparam int TW = tag_w(NREQ);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TW-1:0] last_grant;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] idx_t;
    logic          gnt_any;
    logic [GW-1:0] gap_cnt;
    logic          can_issue;
    logic          xfer;
    logic          pop;
    logic [TW-1:0] pop_tag;
    logic          fifo_empty;
    logic          unused_full;
    logic [CW-1:0] fifo_count;
    int            idx;

    // First valid requester after the last grant wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_t   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(last_grant) + k) % NREQ;
            idx_t = TW'(idx);
            if (!gnt_any && req_valid_i[idx_t]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_t;
            end
        end
    end

    // A full FIFO blocks issue even when a pop lands this cycle.
    assign can_issue = rstn_i && (gap_cnt == '0) &&
                       (fifo_count < CW'(DEPTH));

    assign req_ready_o = (can_issue && gnt_any) ?
                         (NREQ'(1) << gnt_idx) : '0;
    assign xfer = |req_ready_o;
    assign pop  = core_valid_i && !fifo_empty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_grant   <= TW'(NREQ - 1);
            gap_cnt      <= '0;
            core_valid_o <= 1'b0;
            core_x_o     <= '0;
            core_y_o     <= '0;
        end else begin
            core_valid_o <= xfer;
            if (xfer) begin
                last_grant <= gnt_idx;
                core_x_o   <= req_x_i[gnt_idx];
                core_y_o   <= req_y_i[gnt_idx];
                gap_cnt    <= GW'(ISSUE_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rsp_valid_o <= '0;
            rsp_r_o     <= '0;
            rsp_angle_o <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= pop ? (NREQ'(1) << pop_tag) : '0;
            if (pop) begin
                rsp_r_o     <= core_r_i;
                rsp_angle_o <= {core_quadrant_i, core_angle_i};
            end
            if (core_valid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH),
        .TW    (TW)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push     (xfer),
        .push_tag (gnt_idx),
        .pop      (pop),
        .pop_tag  (pop_tag),
        .full     (unused_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_vectoring_scheduler.sv
// Bench for two scheduler configurations against a
// queue-based model of arbitration, gap, depth and routing.
module tb_vectoring_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int FW = AW + 2;
    localparam int QS = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic [N-1:0]         rv [2];
    logic [N-1:0]         rr [2];
    logic [N-1:0][DW-1:0] rx [2];
    logic [N-1:0][DW-1:0] ry [2];
    logic                 cv [2];
    logic [DW-1:0]        cx [2];
    logic [DW-1:0]        cy [2];
    logic                 kv [2];
    logic [DW-1:0]        kr [2];
    logic [AW-1:0]        ka [2];
    logic [1:0]           kq [2];
    logic [N-1:0]         sv [2];
    logic [DW-1:0]        sr [2];
    logic [FW-1:0]        sa [2];
    logic                 er [2];

    int last [2], gap [2], pre_cnt [2];
    int tq [2][QS];
    int th [2], tt [2];
    int cq_due [2][QS];
    logic [DW-1:0] cq_x [2][QS];
    logic [DW-1:0] cq_y [2][QS];
    int ch [2], ct [2];
    bit p_iss [2], p_err [2], e_err [2];
    logic [DW-1:0] p_x [2], p_y [2], p_r [2], h_r [2];
    logic [FW-1:0] p_a [2], h_a [2];
    logic [N-1:0] p_rv [2];
    bit auto_ret [2], fix2 [2];
    int credit [2];
    int cyc, total, bad;
    logic [1:0] m;

    always #5 clk = ~clk;

    vectoring_scheduler #(
        .NREQ(N), .DW(DW), .AW(AW),
        .ISSUE_GAP(1), .DEPTH(32)
    ) u0 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(rv[0]), .req_ready_o(rr[0]),
        .req_x_i(rx[0]), .req_y_i(ry[0]),
        .core_valid_o(cv[0]), .core_x_o(cx[0]),
        .core_y_o(cy[0]), .core_valid_i(kv[0]),
        .core_r_i(kr[0]), .core_angle_i(ka[0]),
        .core_quadrant_i(kq[0]), .rsp_valid_o(sv[0]),
        .rsp_r_o(sr[0]), .rsp_angle_o(sa[0]),
        .err_o(er[0])
    );

    vectoring_scheduler #(
        .NREQ(N), .DW(DW), .AW(AW),
        .ISSUE_GAP(4), .DEPTH(4)
    ) u1 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(rv[1]), .req_ready_o(rr[1]),
        .req_x_i(rx[1]), .req_y_i(ry[1]),
        .core_valid_o(cv[1]), .core_x_o(cx[1]),
        .core_y_o(cy[1]), .core_valid_i(kv[1]),
        .core_r_i(kr[1]), .core_angle_i(ka[1]),
        .core_quadrant_i(kq[1]), .rsp_valid_o(sv[1]),
        .rsp_r_o(sr[1]), .rsp_angle_o(sa[1]),
        .err_o(er[1])
    );

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 0) ? 32 : 4;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 18 : 6;
    endfunction

    // Bit-exact stand-in for the core's arithmetic.
    function automatic logic [DW-1:0] ref_r(
        input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x ^ {y[7:0], y[15:8]};
    endfunction

    function automatic logic [AW-1:0] ref_a(
        input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x + y + 16'h1357;
    endfunction

    function automatic logic [1:0] ref_q(
        input logic [DW-1:0] x, input logic [DW-1:0] y);
        return x[15:14] ^ y[1:0];
    endfunction

    task automatic chk(input string tag, input int d,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] cyc=%0d got=%0h want=%0h",
                   tag, d, cyc, obs, exp);
        end
    endtask

    task automatic reset_model(input int d);
        last[d]  = N - 1;
        gap[d]   = 0;
        th[d]    = 0;
        tt[d]    = 0;
        p_iss[d] = 0;
        p_err[d] = 0;
        p_rv[d]  = '0;
        h_r[d]   = '0;
        h_a[d]   = '0;
        e_err[d] = 0;
    endtask

    task automatic check_out(input int d);
        chk("core_valid", d, 64'(cv[d]), 64'(p_iss[d]));
        if (p_iss[d]) begin
            chk("core_x", d, 64'(cx[d]), 64'(p_x[d]));
            chk("core_y", d, 64'(cy[d]), 64'(p_y[d]));
        end
        if (p_rv[d] != '0) begin
            h_r[d] = p_r[d];
            h_a[d] = p_a[d];
        end
        chk("rsp_valid", d, 64'(sv[d]), 64'(p_rv[d]));
        chk("rsp_r", d, 64'(sr[d]), 64'(h_r[d]));
        chk("rsp_angle", d, 64'(sa[d]), 64'(h_a[d]));
        if (p_err[d]) e_err[d] = 1;
        chk("err", d, 64'(er[d]), 64'(e_err[d]));
        p_iss[d] = 0;
        p_rv[d]  = '0;
        p_err[d] = 0;
    endtask

    task automatic drive(input int d, input logic [N-1:0] v,
                         input bit inj);
        bit ret;
        logic [DW-1:0] x, y;
        ret = 0;
        x = '0;
        y = '0;
        rv[d] = v;
        for (int i = 0; i < N; i++) begin
            rx[d][i] = DW'($urandom);
            ry[d][i] = DW'($urandom);
        end
        if (fix2[d]) begin
            rx[d][2] = 16'd100;
            ry[d][2] = 16'd0;
        end
        pre_cnt[d] = tt[d] - th[d];
        if (ch[d] != ct[d] && cq_due[d][ch[d] % QS] <= cyc &&
            (auto_ret[d] || credit[d] > 0)) begin
            if (!auto_ret[d]) credit[d]--;
            x = cq_x[d][ch[d] % QS];
            y = cq_y[d][ch[d] % QS];
            ch[d]++;
            ret = 1;
        end else if (inj) begin
            x = DW'($urandom);
            y = DW'($urandom);
            ret = 1;
        end
        kv[d] = ret;
        kr[d] = ref_r(x, y);
        ka[d] = ref_a(x, y);
        kq[d] = ref_q(x, y);
        if (ret) begin
            if (tt[d] != th[d]) begin
                p_rv[d] = N'(1) << tq[d][th[d] % QS];
                p_r[d]  = ref_r(x, y);
                p_a[d]  = {ref_q(x, y), ref_a(x, y)};
                th[d]++;
            end else begin
                p_err[d] = 1;
            end
        end
    endtask

    task automatic model_grant(input int d);
        int g;
        int idx;
        logic [N-1:0] exp;
        g = -1;
        exp = '0;
        if (gap[d] == 0 && pre_cnt[d] < dep_of(d)) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last[d] + k) % N;
                if (g < 0 && rv[d][idx]) g = idx;
            end
        end
        if (g >= 0) exp = N'(1) << g;
        chk("ready", d, 64'(rr[d]), 64'(exp));
        if (g >= 0) begin
            last[d] = g;
            tq[d][tt[d] % QS] = g;
            tt[d]++;
            p_iss[d] = 1;
            p_x[d] = rx[d][g];
            p_y[d] = ry[d][g];
            cq_due[d][ct[d] % QS] = cyc + lat_of(d);
            cq_x[d][ct[d] % QS] = rx[d][g];
            cq_y[d][ct[d] % QS] = ry[d][g];
            ct[d]++;
            gap[d] = gap_of(d) - 1;
        end else if (gap[d] > 0) begin
            gap[d]--;
        end
    endtask

    task automatic cycle(input logic [N-1:0] v0,
                         input logic [N-1:0] v1,
                         input bit inj0, input bit inj1);
        @(negedge clk);
        check_out(0);
        check_out(1);
        drive(0, v0, inj0);
        drive(1, v1, inj1);
        #1;
        model_grant(0);
        model_grant(1);
        cyc++;
    endtask

    task automatic check_zero(input int d);
        chk("rst_ready", d, 64'(rr[d]), 64'(0));
        chk("rst_core_valid", d, 64'(cv[d]), 64'(0));
        chk("rst_core_x", d, 64'(cx[d]), 64'(0));
        chk("rst_core_y", d, 64'(cy[d]), 64'(0));
        chk("rst_rsp_valid", d, 64'(sv[d]), 64'(0));
        chk("rst_rsp_r", d, 64'(sr[d]), 64'(0));
        chk("rst_rsp_angle", d, 64'(sa[d]), 64'(0));
        chk("rst_err", d, 64'(er[d]), 64'(0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        for (int d = 0; d < 2; d++) begin
            reset_model(d);
            ch[d] = 0;
            ct[d] = 0;
            auto_ret[d] = 1;
            fix2[d] = 0;
            credit[d] = 0;
            rv[d] = '1;
            rx[d] = '0;
            ry[d] = '0;
            kv[d] = 1'b0;
            kr[d] = '0;
            ka[d] = '0;
            kq[d] = '0;
        end

        @(negedge clk);
        check_zero(0);
        check_zero(1);
        rv[0] = '0;
        rv[1] = '0;
        rstn = 1'b1;

        // Saturated round-robin on the pipelined config.
        repeat (12) cycle('1, '0, 0, 0);

        // Requesters 1 and 3 interleaved at random.
        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom);
            cycle({m[1], 1'b0, m[0], 1'b0}, '0, 0, 0);
        end
        repeat (25) cycle('0, '0, 0, 0);

        // Issue gap of 4 with requester 2 alone.
        fix2[1] = 1;
        repeat (12) cycle('0, 4'b0100, 0, 0);
        fix2[1] = 0;
        repeat (10) cycle('0, '0, 0, 0);

        // Stalled core against a depth-4 tag FIFO.
        auto_ret[1] = 0;
        repeat (24) cycle('0, '1, 0, 0);
        credit[1] = 1;
        repeat (12) cycle('0, '1, 0, 0);
        auto_ret[1] = 1;
        repeat (12) cycle('0, '0, 0, 0);

        // Stray core result with nothing in flight.
        cycle('0, '0, 0, 1);
        repeat (3) cycle('0, '0, 0, 0);

        // Reset with three samples inside the core.
        repeat (3) cycle(4'b0001, '0, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        rv[0] = '1;
        rv[1] = '1;
        #1;
        check_zero(0);
        check_zero(1);
        reset_model(0);
        reset_model(1);
        rv[0] = '0;
        rv[1] = '0;
        kv[0] = 1'b0;
        kv[1] = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (22) cycle('0, '0, 0, 0);
        repeat (4) cycle('1, '0, 0, 0);
        repeat (22) cycle('0, '0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vectoring_scheduler.md
VECTORING_SCHEDULER -- requirements
Module: vectoring_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one vectoring core (2..8).
REQ-002 Parameter DW, default 16, x/y/r data width.
REQ-003 Parameter AW, default 16, in-quadrant angle width; full angle is AW+2 bits.
REQ-004 Parameter ISSUE_GAP, default 1, minimum cycles between core issues (1 = every cycle, for pipelined core).
REQ-005 Parameter DEPTH, default 32, maximum in-flight samples (tag FIFO depth, power of 2, at least the core latency).
REQ-006 clk_i  input  1  single clock, all logic rising-edge.
REQ-007 rstn_i  input  1  asynchronous active-low reset.
REQ-008 req_valid_i  input  NREQ  per-requester sample valid.
REQ-009 req_ready_o  output  NREQ  per-requester accept, one-hot or zero.
REQ-010 req_x_i, req_y_i  input  NREQ x DW  signed per-requester operands.
REQ-011 core_valid_o, core_x_o, core_y_o  output  1, DW, DW  issue to the vectoring core.
REQ-012 core_valid_i, core_r_i, core_angle_i, core_quadrant_i  input  1, DW, AW, 2  core result.
REQ-013 rsp_valid_o  output  NREQ  one-hot result strobe to the owning requester.
REQ-014 rsp_r_o, rsp_angle_o  output  DW, AW+2  result; angle = {quadrant, in-quadrant angle}.
REQ-015 err_o  output  1  sticky protocol error.

Function
REQ-016 A request transfers in a cycle where req_valid_i[i] and req_ready_o[i] are both high; req_ready_o SHALL be combinational from req_valid_i, arbiter state, gap counter and FIFO count.
REQ-017 Issue is allowed when the gap counter is 0 and the in-flight count is below DEPTH; otherwise req_ready_o is all-zero.
REQ-018 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NREQ; last_grant updates only on a transfer.
REQ-019 On transfer from i, core_valid_o/core_x_o/core_y_o SHALL present that sample on the next cycle for exactly one cycle (latency 1); core_valid_o is low otherwise.
REQ-020 On transfer, the gap counter loads ISSUE_GAP-1 and decrements to 0; ISSUE_GAP=1 never blocks.
REQ-021 On transfer, requester index i SHALL be pushed to the tag FIFO; the core is in-order, so each core_valid_i pops one tag.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged; a full FIFO blocks issue even if a pop occurs that cycle.
REQ-023 On core_valid_i with a non-empty FIFO, one cycle later rsp_valid_o[popped tag] pulses high with rsp_r_o = core_r_i and rsp_angle_o = {core_quadrant_i, core_angle_i}.
REQ-024 On core_valid_i with an empty FIFO, the result SHALL be dropped, rsp_valid_o stays zero and err_o sets and holds until reset.
REQ-025 rsp_r_o/rsp_angle_o SHALL hold their last value when rsp_valid_o is zero.
REQ-026 Responses have no backpressure; requesters SHALL accept every rsp_valid_o pulse.

Reset
REQ-027 While rstn_i is low, req_ready_o, core_valid_o, rsp_valid_o and err_o are 0, all data outputs are 0, last_grant is NREQ-1 (requester 0 is first), the gap counter is 0 and the FIFO is empty.
REQ-028 Reset mid-operation SHALL discard all in-flight tags; core results returning after reset set err_o per REQ-024.

Structure
REQ-029 Package vectoring_pkg SHALL hold the tag width function clog2(NREQ) and the full-angle width constant AW+2.
REQ-030 The tag FIFO SHALL be a sub-module named tag_fifo with push, pop, full, empty and count.
REQ-031 The implementation is a pure scheduler; it SHALL NOT instantiate the vectoring core.

Verification
REQ-032 NREQ=4, all req_valid_i high continuously, ISSUE_GAP=1 -> grants in the order 0,1,2,3,0,... with one transfer per cycle.
REQ-033 ISSUE_GAP=4, requester 2 alone with sample x=100, y=0 -> transfers at cycles t, t+4, t+8; core_valid_o is high at t+1, t+5 and t+9.
REQ-034 Core model with 18-cycle latency, DEPTH=32, requesters 1 and 3 interleaved -> every rsp_valid_o pulse reaches the issuing requester, and r/angle match a bit-exact reference with zero mismatches.
REQ-035 DEPTH=4, core stalled (no core_valid_i) -> after 4 transfers req_ready_o stays 0; one core_valid_i re-enables exactly one further transfer.
REQ-036 Inject core_valid_i with an empty FIFO -> rsp_valid_o stays 0 and err_o=1 until rstn_i is asserted.
REQ-037 Assert rstn_i with 3 samples in flight -> all outputs go to 0 asynchronously; grant order restarts at requester 0; the 3 late results raise err_o.
